// File: rtl/map_sst_seq_pkg.sv
// Shared types and constants for the mapper save-state sequencer.
package sst_seq_pkg;

    // Sequencer walk states.
    typedef enum logic [3:0] {
        IDLE,
        SV_HOLD,
        SV_CAP,
        RS_CHK,
        RS_RD,
        RS_LAT,
        RS_WE,
        RS_GAP,
        FIN
    } seq_state_t;

    // Transfer direction as sampled from req_dir.
    typedef enum logic {
        DIR_SAVE    = 1'b0,  // mapper -> buffer
        DIR_RESTORE = 1'b1   // buffer -> mapper
    } seq_dir_t;

    // Save-state address that reads back the mapper index.
    localparam int SST_IDX_ADDR = 127;

endpackage

// File: rtl/map_sst_seq_if.sv
// Control, buffer and SSTBus signals of the save-state sequencer.
// slave = the sequencer; master = menu logic, buffer and mapper around it.
interface map_sst_seq_if;

    logic       req;
    logic       req_dir;
    logic       abort;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0] buf_addr;
    logic       buf_rd;
    logic [7:0] buf_rdata;
    logic       buf_wr;
    logic [7:0] buf_wdata;

    logic       sst_act;
    logic [7:0] sst_addr;
    logic       sst_we_reg;
    logic [7:0] sst_dato;
    logic [7:0] sst_di;

    modport master (
        output req, req_dir, abort, buf_rdata, sst_di,
        input  busy, done, err, buf_addr, buf_rd, buf_wr, buf_wdata,
               sst_act, sst_addr, sst_we_reg, sst_dato
    );

    modport slave (
        input  req, req_dir, abort, buf_rdata, sst_di,
        output busy, done, err, buf_addr, buf_rd, buf_wr, buf_wdata,
               sst_act, sst_addr, sst_we_reg, sst_dato
    );

endinterface

// File: rtl/map_sst_seq_step_tmr.sv
// Hold-phase timer: reloads to STEP_CYC-1 while load is high, then counts
// down; expired marks the last cycle of a STEP_CYC-long hold.
module sst_step_tmr #(
    parameter int STEP_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);

    localparam int TW = $clog2(STEP_CYC + 1);

    logic [TW-1:0] cnt;

    // Reload or count down toward zero, then stay at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= TW'(STEP_CYC - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/map_sst_seq.sv
// Save-state sequencer: walks mapper registers 0..ADDR_LAST over the SSTBus,
// copying them to a byte buffer (save) or back from it (restore). A restore
// first checks the buffered mapper index against the live one.
module map_sst_seq
    import sst_seq_pkg::*;
#(
    parameter int ADDR_LAST = 127,
    parameter int IDX_ADDR  = SST_IDX_ADDR,
    parameter int STEP_CYC  = 4  // >= one m2 period; >= 2 so the index read settles
) (
    input  logic          clk,
    input  logic          rst_n,
    map_sst_seq_if.slave  bus
);

    localparam logic [7:0] LAST_A = 8'(ADDR_LAST);
    localparam logic [7:0] IDX_A  = 8'(IDX_ADDR);

    seq_state_t state;
    logic [7:0] n;
    logic       tmr_load;
    logic       tmr_exp;
    logic [7:0] rs_first;
    logic [8:0] rs_next;
    logic       go_fin;

    // The timer only runs inside hold phases; it sits preloaded everywhere else.
    assign tmr_load = !(state inside {SV_HOLD, RS_CHK, RS_WE});

    sst_step_tmr #(.STEP_CYC(STEP_CYC)) u_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .expired (tmr_exp)
    );

    // Restore addresses skip the index register; 9 bits so the end test
    // cannot wrap when ADDR_LAST is 255.
    assign rs_first = (IDX_A == 8'd0) ? 8'd1 : 8'd0;
    assign rs_next  = (({1'b0, n} + 9'd1) == {1'b0, IDX_A}) ? {1'b0, n} + 9'd2
                                                            : {1'b0, n} + 9'd1;

    // Every route into FIN: abort, index mismatch, or end of either walk.
    assign go_fin = ((state != IDLE) && (state != FIN) && bus.abort)
                 || ((state == SV_CAP) && (n == LAST_A))
                 || ((state == RS_CHK) && tmr_exp && (bus.buf_rdata != bus.sst_di))
                 || ((state == RS_GAP) && (rs_next > {1'b0, LAST_A}));

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            n              <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.buf_addr   <= '0;
            bus.buf_rd     <= 1'b0;
            bus.buf_wr     <= 1'b0;
            bus.buf_wdata  <= '0;
            bus.sst_act    <= 1'b0;
            bus.sst_addr   <= '0;
            bus.sst_we_reg <= 1'b0;
            bus.sst_dato   <= '0;
        end else begin
            // NOTE: done defaults low every cycle so it can only ever be a
            // single-cycle pulse, whichever branch raises it.
            bus.done <= 1'b0;
            if (go_fin) begin
                // Strobes drop on this very edge; nothing is stretched.
                state          <= FIN;
                bus.busy       <= 1'b0;
                bus.sst_act    <= 1'b0;
                bus.done       <= 1'b1;
                bus.buf_rd     <= 1'b0;
                bus.buf_wr     <= 1'b0;
                bus.sst_we_reg <= 1'b0;
                if (bus.abort || state == RS_CHK) bus.err <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (bus.req) begin
                        bus.err     <= 1'b0;
                        bus.busy    <= 1'b1;
                        bus.sst_act <= 1'b1;
                        n           <= '0;
                        if (seq_dir_t'(bus.req_dir) == DIR_RESTORE) begin
                            bus.sst_addr <= IDX_A;
                            bus.buf_addr <= IDX_A;
                            bus.buf_rd   <= 1'b1;
                            state        <= RS_CHK;
                        end else begin
                            bus.sst_addr <= '0;
                            state        <= SV_HOLD;
                        end
                    end
                    SV_HOLD: if (tmr_exp) begin
                        bus.buf_wr    <= 1'b1;
                        bus.buf_addr  <= n;
                        bus.buf_wdata <= bus.sst_di;
                        state         <= SV_CAP;
                    end
                    SV_CAP: begin
                        bus.buf_wr   <= 1'b0;
                        n            <= n + 8'd1;
                        bus.sst_addr <= n + 8'd1;
                        state        <= SV_HOLD;
                    end
                    // Index matched (mismatch is handled by go_fin).
                    RS_CHK: if (tmr_exp) begin
                        n            <= rs_first;
                        bus.buf_addr <= rs_first;
                        bus.sst_addr <= rs_first;
                        state        <= RS_RD;
                    end
                    RS_RD: begin
                        bus.buf_rd <= 1'b0;
                        state      <= RS_LAT;
                    end
                    RS_LAT: begin
                        bus.sst_dato   <= bus.buf_rdata;
                        bus.sst_we_reg <= 1'b1;
                        state          <= RS_WE;
                    end
                    RS_WE: if (tmr_exp) begin
                        bus.sst_we_reg <= 1'b0;
                        state          <= RS_GAP;
                    end
                    RS_GAP: begin
                        n            <= rs_next[7:0];
                        bus.buf_addr <= rs_next[7:0];
                        bus.sst_addr <= rs_next[7:0];
                        bus.buf_rd   <= 1'b1;
                        state        <= RS_RD;
                    end
                    FIN:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_map_sst_seq.sv
// Bench for map_sst_seq: a synchronous-read byte buffer and a 128-register
// mapper reporting index 0x42, driven through whole save/restore operations.
module tb_map_sst_seq;

    localparam int ADDR_LAST = 127;
    localparam int IDX_ADDR  = 127;
    localparam int STEP_CYC  = 4;
    localparam logic [7:0] MAP_IDX = 8'h42;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    map_sst_seq_if bus ();

    map_sst_seq #(
        .ADDR_LAST (ADDR_LAST),
        .IDX_ADDR  (IDX_ADDR),
        .STEP_CYC  (STEP_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- environment models ----------------
    logic [7:0] buf_mem [256];
    logic [7:0] map_reg [128];
    int         wr_cnt  [128];
    logic       prep, prep_restore;
    logic [7:0] prep_b0, prep_bidx;
    logic       we_prev;
    logic [7:0] addr_prev, dato_prev;
    int         we_pulses, we_cur, we_min, we_max, unstable;

    assign bus.sst_di = (bus.sst_addr == 8'(IDX_ADDR)) ? MAP_IDX : map_reg[bus.sst_addr[6:0]];

    // Buffer, mapper and strobe monitor; prep reloads the initial images.
    always @(posedge clk) begin
        if (bus.buf_rd) bus.buf_rdata <= buf_mem[bus.buf_addr];
        if (prep) begin
            for (int i = 0; i < 256; i++) buf_mem[i] <= prep_restore ? 8'hFF : 8'h00;
            if (prep_restore) begin
                buf_mem[0]        <= prep_b0;
                buf_mem[IDX_ADDR] <= prep_bidx;
            end
            for (int i = 0; i < 128; i++) begin
                map_reg[i] <= 8'hFF;
                wr_cnt[i]  <= 0;
            end
            map_reg[0] <= 8'h2B;
            we_prev    <= 1'b0;
            we_pulses  <= 0;
            we_cur     <= 0;
            we_min     <= 1000;
            we_max     <= 0;
            unstable   <= 0;
        end else begin
            if (bus.buf_wr) buf_mem[bus.buf_addr] <= bus.buf_wdata;
            if (bus.sst_we_reg) begin
                if (!we_prev) begin
                    map_reg[bus.sst_addr[6:0]] <= bus.sst_dato;
                    wr_cnt[bus.sst_addr[6:0]]  <= wr_cnt[bus.sst_addr[6:0]] + 1;
                    we_pulses <= we_pulses + 1;
                    we_cur    <= 1;
                end else begin
                    we_cur <= we_cur + 1;
                    if (bus.sst_addr != addr_prev || bus.sst_dato != dato_prev)
                        unstable <= unstable + 1;
                end
            end else if (we_prev) begin
                if (we_cur < we_min) we_min <= we_cur;
                if (we_cur > we_max) we_max <= we_cur;
            end
            we_prev   <= bus.sst_we_reg;
            addr_prev <= bus.sst_addr;
            dato_prev <= bus.sst_dato;
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_env(input logic restore, input logic [7:0] b0, input logic [7:0] bidx);
        @(negedge clk);
        prep_restore = restore;
        prep_b0      = b0;
        prep_bidx    = bidx;
        prep         = 1'b1;
        @(negedge clk);
        prep         = 1'b0;
    endtask

    // Pulse req for one cycle; returns at the negedge of cycle 1 (req = cycle 0).
    task automatic start_req(input logic dir);
        @(negedge clk);
        bus.req     = 1'b1;
        bus.req_dir = dir;
        @(negedge clk);
        bus.req     = 1'b0;
    endtask

    // Inclusive cycle count from the req cycle to the done cycle; 0 on timeout.
    task automatic wait_done(input int start, output int incl);
        int c;
        c = start;
        while (!bus.done && c < 3000) begin
            @(negedge clk);
            c++;
        end
        incl = bus.done ? c + 1 : 0;
    endtask

    function automatic int save_image_errors();
        int bad;
        logic [7:0] e;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            e = (i == 0) ? 8'h2B : (i == IDX_ADDR) ? MAP_IDX : (i <= ADDR_LAST) ? 8'hFF : 8'h00;
            if (buf_mem[i] !== e) bad++;
        end
        return bad;
    endfunction

    // ---------------- vectors ----------------
    typedef struct {
        logic       dir;
        logic [7:0] b_idx;
        logic [7:0] b0;
        logic       exp_err;
        int         exp_cycles;
        int         exp_writes;
        logic [7:0] exp_reg0;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int incl, c, bad;
        logic seen;

        // Save: 128 x 5 + 2 ; restore: 1 + 4 + 127 x 7 + 1 ; bad index: 1 + 4 + 1.
        vecs[0] = '{1'b0, 8'h00, 8'h00, 1'b0, 642,   0, 8'h2B};
        vecs[1] = '{1'b1, 8'h42, 8'h15, 1'b0, 895, 127, 8'h15};
        vecs[2] = '{1'b1, 8'h24, 8'h15, 1'b1,   6,   0, 8'h2B};
        vecs[3] = '{1'b1, 8'h42, 8'hA7, 1'b0, 895, 127, 8'hA7};

        bus.req = 1'b0; bus.req_dir = 1'b0; bus.abort = 1'b0;
        prep = 1'b0; prep_restore = 1'b0; prep_b0 = 8'h00; prep_bidx = 8'h00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ctrl outputs",
              {bus.busy, bus.done, bus.err, bus.sst_act, bus.sst_we_reg, bus.buf_rd, bus.buf_wr}, 32'd0);
        check("reset data outputs", {bus.sst_addr, bus.buf_addr, bus.buf_wdata, bus.sst_dato}, 32'd0);
        rst_n = 1'b1;

        // ---- table-driven whole operations ----
        for (int v = 0; v < 4; v++) begin
            load_env(vecs[v].dir, vecs[v].b0, vecs[v].b_idx);
            start_req(vecs[v].dir);
            check($sformatf("v%0d accept busy/act", v), {bus.busy, bus.sst_act}, 32'h3);
            check($sformatf("v%0d err cleared", v), bus.err, 1'b0);
            wait_done(1, incl);
            check($sformatf("v%0d cycles req..done", v), incl, vecs[v].exp_cycles);
            check($sformatf("v%0d err at done", v), bus.err, vecs[v].exp_err);
            check($sformatf("v%0d busy/act at done", v), {bus.busy, bus.sst_act}, 32'h0);
            @(negedge clk);
            check($sformatf("v%0d done one cycle", v), bus.done, 1'b0);
            check($sformatf("v%0d mapper writes", v), we_pulses, vecs[v].exp_writes);
            check($sformatf("v%0d mapper reg0", v), map_reg[0], vecs[v].exp_reg0);
            if (vecs[v].dir == 1'b0) begin
                check($sformatf("v%0d buffer[127]", v), buf_mem[IDX_ADDR], MAP_IDX);
                check($sformatf("v%0d buffer image bad bytes", v), save_image_errors(), 0);
            end else if (!vecs[v].exp_err) begin
                bad = 0;
                for (int i = 0; i < 128; i++) if (wr_cnt[i] != ((i == IDX_ADDR) ? 0 : 1)) bad++;
                check($sformatf("v%0d per-address write counts", v), bad, 0);
                check($sformatf("v%0d we_reg width min/max", v), {we_min[15:0], we_max[15:0]}, {16'd4, 16'd4});
                check($sformatf("v%0d addr/dato stable under we", v), unstable, 0);
            end
        end

        // ---- abort on the 3rd cycle of RS_WE at n=0 ----
        load_env(1'b1, 8'h15, MAP_IDX);
        start_req(1'b1);
        c = 0;
        while (!bus.sst_we_reg && c < 100) begin @(negedge clk); c++; end
        check("abort: first we_reg at n=0", {bus.sst_we_reg, bus.sst_addr}, {23'd0, 1'b1, 8'd0});
        repeat (2) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort: we_reg dropped", bus.sst_we_reg, 1'b0);
        check("abort: done/err/act/busy", {bus.done, bus.err, bus.sst_act, bus.busy}, 32'b1100);
        @(negedge clk);
        check("abort: err sticky, done gone", {bus.err, bus.done}, 32'b10);

        // ---- reset mid-save at n=10 ----
        load_env(1'b0, 8'h00, 8'h00);
        start_req(1'b0);
        c = 0;
        while (bus.sst_addr != 8'd10 && c < 200) begin @(negedge clk); c++; end
        check("rst: save reached n=10", bus.sst_addr, 8'd10);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst: async ctrl outputs",
              {bus.busy, bus.done, bus.err, bus.sst_act, bus.sst_we_reg, bus.buf_rd, bus.buf_wr}, 32'd0);
        check("rst: async sst_addr/wdata", {bus.sst_addr, bus.buf_wdata}, 32'd0);
        seen = 1'b0;
        repeat (4) begin @(negedge clk); seen |= bus.done; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); seen |= bus.done; end
        check("rst: no done pulse", seen, 1'b0);
        load_env(1'b0, 8'h00, 8'h00);
        start_req(1'b0);
        wait_done(1, incl);
        check("rst: full save after reset cycles", incl, 642);
        check("rst: full save image bad bytes", save_image_errors(), 0);

        // ---- req pulses while busy are ignored ----
        load_env(1'b0, 8'h00, 8'h00);
        start_req(1'b0);
        repeat (99) @(negedge clk);
        bus.req = 1'b1; bus.req_dir = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (199) @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0; bus.req_dir = 1'b0;
        wait_done(301, incl);
        check("busy req: save length unchanged", incl, 642);
        check("busy req: err clear", bus.err, 1'b0);
        check("busy req: image intact", save_image_errors(), 0);
        repeat (3) @(negedge clk);
        check("busy req: no late accept", bus.busy, 1'b0);

        // ---- req and abort together in IDLE ----
        @(negedge clk);
        bus.req = 1'b1; bus.abort = 1'b1; bus.req_dir = 1'b0;
        @(negedge clk);
        bus.req = 1'b0;
        check("req+abort: accepted", {bus.busy, bus.sst_act}, 32'h3);
        @(negedge clk);
        bus.abort = 1'b0;
        check("req+abort: done with err", {bus.done, bus.err, bus.busy}, 32'b110);
        @(negedge clk);
        check("req+abort: back to idle", {bus.busy, bus.done}, 32'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
